alu_sequencer: RTL and testbench

Multi-cycle controller that sequences the shared 4-bit add/sub ALU. It accepts 12-bit instructions over a valid/ready handshake and holds a 4×4-bit register file. For each instruction it drives the ALU operands and `alu_op`, then writes the result back and updates the status flags. It sits between the instruction source (switch/FSM front end) and the ALU, and exposes one register read port for display.

---
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state controller (IDLE, DECODE, EXEC, WB) that drives a
// shared external 4-bit add/sub ALU and owns a 4x4-bit register file.
// Optional feature macro: ALU_SEQ_OVF_EN builds the carry/borrow flag logic;
// without it, ovf is tied to 0.
//
// Handshake: an instruction is transferred on a rising edge where
// instr_valid & instr_ready are both 1. instr_ready is high only in IDLE, so
// instr_valid in any other state is ignored and nothing is captured.
module alu_sequencer #(
   parameter int NREGS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [3:0]  alu_srca,
   output logic [3:0]  alu_srcb,
   output logic        alu_op,
   input  logic [3:0]  alu_result,
   input  logic [1:0]  rd_sel,
   output logic [3:0]  rd_data,
   output logic        done,
   output logic        zero,
   output logic        ovf,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      WB     = 2'd3
   } state_t;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_CMP  = 2'b11;

   state_t      state, state_nx;
   logic [11:0] ir;
   logic [3:0]  res;
   logic [3:0]  regs [NREGS];

   logic [1:0]  ir_op, ir_dst, ir_rega, ir_regb;
   logic [3:0]  ir_imm;

   assign ir_op   = ir[11:10];
   assign ir_dst  = ir[9:8];
   assign ir_rega = ir[7:6];
   assign ir_regb = ir[5:4];
   assign ir_imm  = ir[3:0];

   assign instr_ready = (state == IDLE);
   assign rd_data     = regs[rd_sel];
   assign state_dbg   = state;

   // Next-state decode: fixed walk through the four states, waiting only in IDLE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (instr_valid) state_nx = DECODE;
         DECODE:  state_nx = EXEC;
         EXEC:    state_nx = WB;
         WB:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register plus datapath: capture, operand fetch, result sample, writeback.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ir       <= 12'd0;
         res      <= 4'd0;
         alu_srca <= 4'd0;
         alu_srcb <= 4'd0;
         alu_op   <= 1'b0;
         done     <= 1'b0;
         zero     <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= 4'd0;
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid) ir <= instr;
            end
            DECODE: begin
               // Operands are read here, before WB, so dst may alias a source.
               alu_srca <= regs[ir_rega];
               alu_srcb <= regs[ir_regb];
               alu_op   <= (ir_op == OP_ADD) || (ir_op == OP_LOAD);
            end
            EXEC: begin
               res  <= alu_result;
               done <= 1'b1;  // high during the WB cycle
            end
            WB: begin
               case (ir_op)
                  OP_LOAD: regs[ir_dst] <= ir_imm;
                  OP_ADD, OP_SUB: begin
                     regs[ir_dst] <= res;
                     zero         <= (res == 4'd0);
                  end
                  OP_CMP:  zero <= (res == 4'd0);
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_OVF_EN
   logic       ovf_cand;
   logic       ovf_q;
   logic [4:0] sum5;

   assign sum5 = {1'b0, alu_srca} + {1'b0, alu_srcb};
   assign ovf  = ovf_q;

   // Carry (ADD) or unsigned borrow (SUB/CMP) picked in EXEC, committed in WB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_cand <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (state == EXEC) begin
         ovf_cand <= (ir_op == OP_ADD) ? sum5[4] : (alu_srca < alu_srcb);
      end else if (state == WB && ir_op != OP_LOAD) begin
         ovf_q <= ovf_cand;
      end
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed bench for alu_sequencer with a
// behavioural ALU and an architectural register/flag model.
module tb_alu_sequencer;

   logic        clk;
   logic        rst_n;
   logic [11:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  alu_srca;
   logic [3:0]  alu_srcb;
   logic        alu_op;
   logic [3:0]  alu_result;
   logic [1:0]  rd_sel;
   logic [3:0]  rd_data;
   logic        done;
   logic        zero;
   logic        ovf;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   // architectural model
   int m_regs [4];
   bit m_zero;
   bit m_ovf;

   alu_sequencer #(.NREGS(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_srca    (alu_srca),
      .alu_srcb    (alu_srcb),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .rd_sel      (rd_sel),
      .rd_data     (rd_data),
      .done        (done),
      .zero        (zero),
      .ovf         (ovf),
      .state_dbg   (state_dbg)
   );

   // external combinational ALU
   assign alu_result = alu_op ? (alu_srca + alu_srcb) : (alu_srca - alu_srcb);

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit exp_ovf();
`ifdef ALU_SEQ_OVF_EN
      return m_ovf;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [11:0] mk(input int op, input int dst, input int ra, input int rb, input int imm);
      logic [11:0] v;
      v = {op[1:0], dst[1:0], ra[1:0], rb[1:0], imm[3:0]};
      return v;
   endfunction

   function automatic void model_apply(input logic [11:0] i);
      int a, b, s, r;
      a = m_regs[i[7:6]];
      b = m_regs[i[5:4]];
      case (i[11:10])
         2'b00: m_regs[i[9:8]] = int'(i[3:0]);
         2'b01: begin
            s = a + b;
            m_regs[i[9:8]] = s % 16;
            m_zero = ((s % 16) == 0);
            m_ovf  = (s > 15);
         end
         default: begin
            r = (a - b + 16) % 16;
            if (i[11:10] == 2'b10) m_regs[i[9:8]] = r;
            m_zero = (r == 0);
            m_ovf  = (a < b);
         end
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      instr_valid = 1'b0;
      instr = 12'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int r = 0; r < 4; r++) m_regs[r] = 0;
      m_zero = 0;
      m_ovf  = 0;
   endtask

   task automatic check_regs(input string tag);
      for (int r = 0; r < 4; r++) begin
         rd_sel = r[1:0];
         #1;
         checks++;
         if (rd_data !== m_regs[r][3:0]) begin
            errors++;
            $display("FAIL %s reg%0d got %0d want %0d", tag, r, rd_data, m_regs[r]);
         end
      end
   endtask

   task automatic check_flags(input string tag);
      checks++;
      if (zero !== m_zero) begin
         errors++;
         $display("FAIL %s zero got %0b want %0b", tag, zero, m_zero);
      end
      checks++;
      if (ovf !== exp_ovf()) begin
         errors++;
         $display("FAIL %s ovf got %0b want %0b", tag, ovf, exp_ovf());
      end
   endtask

   // One instruction with cycle-exact checks; junk is held valid while busy.
   task automatic issue(input logic [11:0] i);
      int a, b;
      bit exp_op;
      a = m_regs[i[7:6]];
      b = m_regs[i[5:4]];
      exp_op = (i[11:10] == 2'b00) || (i[11:10] == 2'b01);
      @(negedge clk);
      instr = i;
      instr_valid = 1'b1;
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready got %0b want 1", instr_ready);
      end
      @(negedge clk);  // DECODE
      instr = 12'($urandom);
      checks++;
      if (instr_ready !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL decode_cycle ready=%0b done=%0b want 0 0", instr_ready, done);
      end
      @(negedge clk);  // EXEC
      instr = 12'($urandom);
      checks++;
      if (alu_op !== exp_op || alu_srca !== a[3:0] || alu_srcb !== b[3:0]) begin
         errors++;
         $display("FAIL exec_operands op=%0b a=%0d b=%0d want %0b %0d %0d", alu_op, alu_srca, alu_srcb, exp_op, a, b);
      end
      @(negedge clk);  // WB
      instr = 12'($urandom);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse got %0b want 1", done);
      end
      model_apply(i);
      @(negedge clk);  // back in IDLE
      instr_valid = 1'b0;
      checks++;
      if (done !== 1'b0 || instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL retire done=%0b ready=%0b want 0 1", done, instr_ready);
      end
      check_flags("retire");
      check_regs("retire");
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (instr_ready !== 1'b1 || done !== 1'b0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_ctrl ready=%0b done=%0b state=%0d want 1 0 0", instr_ready, done, state_dbg);
      end
      checks++;
      if (alu_srca !== 4'd0 || alu_srcb !== 4'd0 || alu_op !== 1'b0) begin
         errors++;
         $display("FAIL reset_alu a=%0d b=%0d op=%0b want 0 0 0", alu_srca, alu_srcb, alu_op);
      end
      check_flags("reset");
      check_regs("reset");
   endtask

   task automatic test_directed();
      do_reset();
      issue(mk(0, 1, 0, 0, 9));   // LOAD r1=9
      issue(mk(0, 2, 0, 0, 4));   // LOAD r2=4
      issue(mk(1, 3, 1, 2, 0));   // ADD r3=r1+r2 -> 13
      checks++;
      if (rd_data !== 4'd4 && rd_sel == 2'd3) begin end
      rd_sel = 2'd3;
      #1;
      if (rd_data !== 4'd13) begin
         errors++;
         $display("FAIL add_9_4 got %0d want 13", rd_data);
      end
      issue(mk(1, 0, 1, 1, 0));   // ADD r0=r1+r1 -> 2, carry
      issue(mk(2, 3, 2, 1, 0));   // SUB r3=r2-r1 -> 11, borrow
      issue(mk(3, 0, 1, 1, 0));   // CMP r1,r1 -> zero
      checks++;
      if (zero !== 1'b1) begin
         errors++;
         $display("FAIL cmp_equal zero got %0b want 1", zero);
      end
   endtask

   task automatic test_dependent_chain();
      do_reset();
      issue(mk(0, 1, 0, 0, 9));
      issue(mk(0, 2, 0, 0, 4));
      issue(mk(1, 1, 1, 2, 0));   // r1=13
      issue(mk(1, 1, 1, 2, 0));   // r1=1
      rd_sel = 2'd1;
      #1;
      checks++;
      if (rd_data !== 4'd1) begin
         errors++;
         $display("FAIL chain_r1 got %0d want 1", rd_data);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         issue(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 15)));
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] exp_q[$];
      int k, prev, cyc;
      bit rdy;
      for (int n = 0; n < 6; n++)
         exp_q.push_back(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 15)));
      k = 0;
      prev = -1;
      cyc = 0;
      while (k < 6 && cyc < 60) begin
         @(negedge clk);
         instr_valid = 1'b1;
         rdy = instr_ready;
         instr = rdy ? exp_q[k] : 12'($urandom);
         @(posedge clk);
         if (rdy) begin
            if (prev >= 0) begin
               checks++;
               if (cyc - prev !== 4) begin
                  errors++;
                  $display("FAIL b2b_spacing got %0d want 4", cyc - prev);
               end
            end
            model_apply(exp_q[k]);
            prev = cyc;
            k++;
         end
         cyc++;
      end
      checks++;
      if (k != 6) begin
         errors++;
         $display("FAIL b2b_accepts got %0d want 6", k);
      end
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_flags("b2b");
      check_regs("b2b");
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue(mk(0, 1, 0, 0, 9));
      issue(mk(0, 2, 0, 0, 4));
      @(negedge clk);
      instr = mk(1, 3, 1, 2, 0);
      instr_valid = 1'b1;
      @(negedge clk);  // DECODE
      instr_valid = 1'b0;
      @(negedge clk);  // EXEC
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int r = 0; r < 4; r++) m_regs[r] = 0;
      m_zero = 0;
      m_ovf  = 0;
      checks++;
      if (instr_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset ready=%0b done=%0b want 1 0", instr_ready, done);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_done cycle %0d got 1 want 0", c);
         end
      end
      check_flags("mid_reset");
      check_regs("mid_reset");
   endtask

   initial begin
      rst_n = 1'b0;
      instr = 12'd0;
      instr_valid = 1'b0;
      rd_sel = 2'd0;
      test_reset();
      test_directed();
      test_dependent_chain();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
